songsel_ctrl: RTL and testbench

Controller for the song-selection screen. It turns already-debounced up/down/confirm button levels into the registered 2-bit `song` index that drives the selection-screen pixel generator. It provides auto-repeat while a direction is held and drives a blinking cursor-enable for the red selection marker. On confirm it hands the chosen song to the game core through a req/ack handshake.

---
 rtl/songsel_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_songsel_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/songsel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : songsel_ctrl
// Purpose  : Song-selection screen controller. Turns debounced up/down/ok
//            button levels into a registered 2-bit song index with
//            auto-repeat and a cursor enable for the selection marker.
//            Hands the chosen song to the game core over start_req/start_ack.
// Options  : define SONGSEL_BLINK_EN to blink the cursor while browsing.
//            Without it the cursor is steady on in BROWSE and no blink
//            counter exists.
// Revision : 1.0 - initial release
// ============================================================================
module songsel_ctrl #(
  parameter int NUM_SONGS    = 4,
  parameter int DEFAULT_SONG = 3,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 8,
  parameter int BLINK_HALF   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_ok,
  input  logic       start_ack,
  output logic [1:0] song,
  output logic       cursor_on,
  output logic       start_req,
  output logic       locked
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BROWSE  = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam int              HOLD_W      = $clog2(REPEAT_DELAY + 1);
  localparam logic [HOLD_W-1:0] HOLD_TRIP   = HOLD_W'(REPEAT_DELAY);
  // Reloading here makes the next trip exactly REPEAT_RATE ticks away.
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [1:0]      SONG_LAST   = 2'(NUM_SONGS - 1);
  localparam logic [1:0]      SONG_RESET  = 2'(DEFAULT_SONG);

  // Reject parameter sets the index arithmetic cannot honour.
  generate
    if (NUM_SONGS < 2 || NUM_SONGS > 4 || DEFAULT_SONG < 0 ||
        DEFAULT_SONG >= NUM_SONGS || BLINK_HALF < 1 ||
        REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_params
      $error("songsel_ctrl: invalid parameter set");
    end
  endgenerate

  state_t              state_q, state_d;
  logic [1:0]          song_q, song_d;
  logic                cursor_on_q, cursor_on_d;
  logic                start_req_q, start_req_d;
  logic                locked_q, locked_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                btn_up_q, btn_down_q, btn_ok_q;
  logic                step_up, step_dn;

`ifdef SONGSEL_BLINK_EN
  localparam int               BLINK_W    = $clog2(BLINK_HALF + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
`endif

  // Press detection: rising edge against last cycle's level.
  wire up_press = btn_up   & ~btn_up_q;
  wire dn_press = btn_down & ~btn_down_q;
  wire ok_press = btn_ok   & ~btn_ok_q;
  wire [HOLD_W-1:0] hold_inc = hold_cnt_q + HOLD_W'(1);

  // Next-state, index stepping, auto-repeat and cursor logic.
  always_comb begin
    state_d     = state_q;
    song_d      = song_q;
    cursor_on_d = cursor_on_q;
    start_req_d = 1'b0;
    locked_d    = 1'b0;
    hold_cnt_d  = '0;
    step_up     = 1'b0;
    step_dn     = 1'b0;
`ifdef SONGSEL_BLINK_EN
    blink_cnt_d = blink_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        cursor_on_d = 1'b0;
        if (enable) begin
          state_d     = BROWSE;
          cursor_on_d = 1'b1;
`ifdef SONGSEL_BLINK_EN
          blink_cnt_d = '0;
`endif
        end
      end
      BROWSE: begin
        if (!enable) begin
          state_d     = IDLE;
          cursor_on_d = 1'b0;
        end else if (ok_press) begin
          state_d     = CONFIRM;
          start_req_d = 1'b1;
          cursor_on_d = 1'b1;
        end else begin
          if (btn_up && btn_down) begin
            hold_cnt_d = '0;
          end else if (up_press) begin
            step_up = 1'b1;
          end else if (dn_press) begin
            step_dn = 1'b1;
          end else if (btn_up || btn_down) begin
            // One direction held: count frames, trip, then repeat at rate.
            hold_cnt_d = hold_cnt_q;
            if (frame_tick && hold_cnt_q != HOLD_TRIP) begin
              if (hold_inc == HOLD_TRIP) begin
                hold_cnt_d = HOLD_RELOAD;
                step_up    = btn_up;
                step_dn    = btn_down;
              end else begin
                hold_cnt_d = hold_inc;
              end
            end
          end
          if (step_up) begin
            song_d = (song_q == SONG_LAST) ? 2'd0 : song_q + 2'd1;
          end else if (step_dn) begin
            song_d = (song_q == 2'd0) ? SONG_LAST : song_q - 2'd1;
          end
`ifdef SONGSEL_BLINK_EN
          if (step_up || step_dn) begin
            cursor_on_d = 1'b1;
            blink_cnt_d = '0;
          end else if (frame_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
              cursor_on_d = ~cursor_on_q;
              blink_cnt_d = '0;
            end else begin
              blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
          end
`else
          cursor_on_d = 1'b1;
`endif
        end
      end
      CONFIRM: begin
        cursor_on_d = 1'b1;
        if (!enable) begin
          state_d     = IDLE;
          cursor_on_d = 1'b0;
        end else if (start_ack) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
        end else begin
          start_req_d = 1'b1;
        end
      end
      LOCKED: begin
        cursor_on_d = 1'b1;
        if (!enable) begin
          state_d     = IDLE;
          cursor_on_d = 1'b0;
        end else begin
          locked_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cursor_on_d = 1'b0;
      end
    endcase
  end

  // State, outputs and button history; history updates in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      song_q      <= SONG_RESET;
      cursor_on_q <= 1'b0;
      start_req_q <= 1'b0;
      locked_q    <= 1'b0;
      hold_cnt_q  <= '0;
      btn_up_q    <= 1'b0;
      btn_down_q  <= 1'b0;
      btn_ok_q    <= 1'b0;
`ifdef SONGSEL_BLINK_EN
      blink_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      cursor_on_q <= cursor_on_d;
      start_req_q <= start_req_d;
      locked_q    <= locked_d;
      hold_cnt_q  <= hold_cnt_d;
      btn_up_q    <= btn_up;
      btn_down_q  <= btn_down;
      btn_ok_q    <= btn_ok;
`ifdef SONGSEL_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
`endif
    end
  end

  assign song      = song_q;
  assign cursor_on = cursor_on_q;
  assign start_req = start_req_q;
  assign locked    = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_songsel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_songsel_ctrl
// Purpose  : Self-checking bench for songsel_ctrl. Directed scenarios plus
//            random button/enable/ack traffic, compared every cycle against
//            a screen-level behavioural model. Honours SONGSEL_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_songsel_ctrl;

  localparam int N_SONGS = 4;
  localparam int DEF     = 3;
  localparam int DELAY   = 30;
  localparam int RATE    = 8;
  localparam int HALF    = 16;

  localparam int M_IDLE = 0, M_BROWSE = 1, M_CONFIRM = 2, M_LOCKED = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0, frame_tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_ok = 1'b0, start_ack = 1'b0;
  logic [1:0] song;
  logic       cursor_on, start_req, locked;

  int n_checks = 0;
  int n_errors = 0;

  // Model: screen mode, index, ticks held in one direction, ticks since
  // the cursor was last forced on, and last-seen button levels.
  int m_mode, m_song, m_held, m_bt;
  bit m_pu, m_pd, m_po;

  songsel_ctrl #(
    .NUM_SONGS   (N_SONGS),
    .DEFAULT_SONG(DEF),
    .REPEAT_DELAY(DELAY),
    .REPEAT_RATE (RATE),
    .BLINK_HALF  (HALF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .frame_tick(frame_tick),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_ok    (btn_ok),
    .start_ack (start_ack),
    .song      (song),
    .cursor_on (cursor_on),
    .start_req (start_req),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_cursor();
    if (m_mode == M_IDLE) return 1'b0;
    if (m_mode != M_BROWSE) return 1'b1;
`ifdef SONGSEL_BLINK_EN
    return ((m_bt / HALF) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step();
    bit upe, dne, oke, moved;
    int nmode;
    if (rst) begin
      m_mode = M_IDLE; m_song = DEF; m_held = 0; m_bt = 0;
      m_pu = 0; m_pd = 0; m_po = 0;
      return;
    end
    upe = btn_up && !m_pu;
    dne = btn_down && !m_pd;
    oke = btn_ok && !m_po;
    nmode = m_mode;
    moved = 0;
    case (m_mode)
      M_IDLE: if (enable) begin nmode = M_BROWSE; m_bt = 0; m_held = 0; end
      M_BROWSE: begin
        if (!enable) begin nmode = M_IDLE; m_held = 0; end
        else if (oke) begin nmode = M_CONFIRM; m_held = 0; end
        else if (btn_up && btn_down) m_held = 0;
        else if (upe) begin m_song = (m_song + 1) % N_SONGS; m_held = 0; moved = 1; end
        else if (dne) begin m_song = (m_song + N_SONGS - 1) % N_SONGS; m_held = 0; moved = 1; end
        else if (btn_up || btn_down) begin
          if (frame_tick) begin
            m_held++;
            if (m_held >= DELAY && (m_held - DELAY) % RATE == 0) begin
              m_song = btn_up ? (m_song + 1) % N_SONGS : (m_song + N_SONGS - 1) % N_SONGS;
              moved = 1;
            end
          end
        end else m_held = 0;
        if (moved) m_bt = 0;
        else if (nmode == M_BROWSE && frame_tick) m_bt++;
      end
      M_CONFIRM: begin
        if (!enable) nmode = M_IDLE;
        else if (start_ack) nmode = M_LOCKED;
      end
      default: if (!enable) nmode = M_IDLE;
    endcase
    m_mode = nmode;
    m_pu = btn_up; m_pd = btn_down; m_po = btn_ok;
  endtask

  // One clock: advance model with the sampled inputs, compare after the edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_eq("song", song, m_song);
    check_eq("cursor_on", cursor_on, exp_cursor());
    check_eq("start_req", start_req, m_mode == M_CONFIRM);
    check_eq("locked", locked, m_mode == M_LOCKED);
  endtask

  task automatic tick_pair();
    frame_tick = 1'b1; cyc();
    frame_tick = 1'b0; cyc();
  endtask

  initial begin
    repeat (2) cyc();
    check_eq("rst_song", song, DEF);
    check_eq("rst_cursor", cursor_on, 0);
    check_eq("rst_req", start_req, 0);
    check_eq("rst_locked", locked, 0);
    rst = 1'b0;

    // Enter BROWSE, wrap up from 3 to 0.
    enable = 1'b1; cyc();
    btn_up = 1'b1; cyc();
    check_eq("wrap_up", song, 0);
    check_eq("browse_cursor", cursor_on, 1);
    btn_up = 1'b0; cyc();
    repeat (2) begin btn_up = 1'b1; cyc(); btn_up = 1'b0; cyc(); end
    check_eq("at_two", song, 2);

    // Auto-repeat while holding down.
    btn_down = 1'b1; cyc();
    check_eq("down_press", song, 1);
    for (int t = 1; t <= 46; t++) begin
      tick_pair();
      if (t == 29) check_eq("rep_before", song, 1);
      if (t == 30) check_eq("rep_first", song, 0);
      if (t == 38) check_eq("rep_second", song, 3);
      if (t == 46) check_eq("rep_third", song, 2);
    end
    btn_down = 1'b0; cyc();
    btn_down = 1'b1; cyc(); btn_down = 1'b0; cyc();
    check_eq("at_one", song, 1);

    // All three rise together: OK wins, no step.
    btn_up = 1'b1; btn_down = 1'b1; btn_ok = 1'b1; cyc();
    check_eq("ok_wins_song", song, 1);
    check_eq("ok_wins_req", start_req, 1);
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (10) cyc();
    check_eq("wait_ack_req", start_req, 1);
    check_eq("wait_ack_song", song, 1);
    start_ack = 1'b1; cyc(); start_ack = 1'b0;
    check_eq("ack_req", start_req, 0);
    check_eq("ack_locked", locked, 1);
    cyc();

    // Abort from CONFIRM, re-enable with OK still held.
    enable = 1'b0; cyc();
    check_eq("leave_locked", locked, 0);
    enable = 1'b1; cyc();
    btn_ok = 1'b0; cyc();
    btn_ok = 1'b1; cyc();
    check_eq("reconfirm_req", start_req, 1);
    enable = 1'b0; cyc();
    check_eq("abort_req", start_req, 0);
    check_eq("abort_cursor", cursor_on, 0);
    enable = 1'b1; cyc();
    check_eq("remember_song", song, 1);
    check_eq("reenter_cursor", cursor_on, 1);
    repeat (5) cyc();
    check_eq("no_reconfirm", start_req, 0);

    // Reset while locked.
    btn_ok = 1'b0; cyc();
    btn_ok = 1'b1; cyc();
    start_ack = 1'b1; cyc(); start_ack = 1'b0; btn_ok = 1'b0;
    check_eq("pre_rst_locked", locked, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    check_eq("rst_lock_song", song, DEF);
    check_eq("rst_lock_locked", locked, 0);
    check_eq("rst_lock_req", start_req, 0);
    check_eq("rst_lock_cursor", cursor_on, 0);
    cyc();

`ifdef SONGSEL_BLINK_EN
    for (int t = 1; t <= 40; t++) begin
      tick_pair();
      if (t == 15) check_eq("blink_on15", cursor_on, 1);
      if (t == 16) check_eq("blink_off16", cursor_on, 0);
      if (t == 31) check_eq("blink_off31", cursor_on, 0);
      if (t == 32) check_eq("blink_on32", cursor_on, 1);
    end
    enable = 1'b0; cyc(); enable = 1'b1; cyc();
    for (int t = 1; t <= 20; t++) tick_pair();
    check_eq("blink_off20", cursor_on, 0);
    btn_up = 1'b1; cyc(); btn_up = 1'b0;
    check_eq("blink_force", cursor_on, 1);
    cyc();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 20000; i++) begin
      rst        = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 99) == 0)  btn_up   = ~btn_up;
      if ($urandom_range(0, 99) == 0)  btn_down = ~btn_down;
      if ($urandom_range(0, 149) == 0) btn_ok   = ~btn_ok;
      if ($urandom_range(0, 399) == 0) enable   = ~enable;
      frame_tick = ($urandom_range(0, 2) == 0);
      start_ack  = ($urandom_range(0, 4) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
